// File: rtl/fpadd_share_arbiter.sv
`default_nettype none
// ============================================================================
// fpadd_share_arbiter : round-robin sharing of one multi-cycle FP adder among
//                       NUM_REQ requesters, with a watchdog on the done pulse.
// Revision 1.0
// ============================================================================
module fpadd_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_dataa,
  input  logic [NUM_REQ*DATA_W-1:0] req_datab,
  output logic [NUM_REQ-1:0]        resp_done,
  output logic [DATA_W-1:0]         resp_result,
  output logic                      resp_timeout,
  output logic                      busy,
  output logic                      fpu_start,
  output logic [DATA_W-1:0]         fpu_dataa,
  output logic [DATA_W-1:0]         fpu_datab,
  input  logic                      fpu_done,
  input  logic [DATA_W-1:0]         fpu_result
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [GW-1:0]     c_last_init = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0]     c_cnt_last  = CW'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] c_qnan      = DATA_W'(32'h7FC00000);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GW-1:0]       r_grant;
  logic [GW-1:0]       r_last;
  logic [CW-1:0]       r_cnt;
  logic                r_timeout;
  logic [DATA_W-1:0]   r_dataa;
  logic [DATA_W-1:0]   r_datab;
  logic [DATA_W-1:0]   r_result;

  logic [GW-1:0]       w_grant;
  logic [GW-1:0]       w_cand;
  logic                w_any_req;
  logic                w_cnt_expired;
  logic [DATA_W-1:0]   w_opa;
  logic [DATA_W-1:0]   w_opb;

  assign w_any_req     = |req_valid;
  assign w_cnt_expired = (r_cnt == c_cnt_last);

  // Scanning from the farthest candidate down to the nearest lets the nearest
  // valid requester after r_last overwrite the others.
  always_comb begin
    w_grant = r_last;
    w_cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = GW'((int'(r_last) + k) % NUM_REQ);
      if (req_valid[w_cand]) begin
        w_grant = w_cand;
      end
    end
  end

  assign w_opa = req_dataa[int'(w_grant)*DATA_W +: DATA_W];
  assign w_opb = req_datab[int'(w_grant)*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clk_en) begin
      case (r_state)
        S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
        S_ISSUE: w_state_nxt = S_WAIT;
        S_WAIT:  if (fpu_done || w_cnt_expired) w_state_nxt = S_RESP;
        S_RESP:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant   <= '0;
      r_last    <= c_last_init;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_dataa   <= '0;
      r_datab   <= '0;
      r_result  <= '0;
    end else if (clk_en) begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_grant;
            r_dataa <= w_opa;
            r_datab <= w_opb;
          end
        end
        S_ISSUE: begin
          r_cnt     <= '0;
          r_timeout <= 1'b0;
        end
        S_WAIT: begin
          // A done arriving on the expiry cycle still delivers the real sum.
          if (fpu_done) begin
            r_result  <= fpu_result;
            r_timeout <= 1'b0;
          end else if (w_cnt_expired) begin
            r_result  <= c_qnan;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_last <= r_grant;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    resp_done = '0;
    if (clk_en && (r_state == S_RESP)) begin
      resp_done[r_grant] = 1'b1;
    end
  end

  assign resp_timeout = clk_en && (r_state == S_RESP) && r_timeout;
  assign resp_result  = r_result;
  assign busy         = (r_state != S_IDLE);
  assign fpu_start    = clk_en && (r_state == S_ISSUE);
  assign fpu_dataa    = r_dataa;
  assign fpu_datab    = r_datab;

endmodule
`default_nettype wire
